// File: rtl/ic0_bus_pkg.sv
// Shared types and constants for the ic0 bus master and its read-return collector.
package ic0_bus_pkg;

    localparam int IC0_DATA_W          = 32;
    localparam int IC0_CNT_W           = 8;
    localparam int IC0_N_SLV_DEFAULT   = 4;
    localparam int IC0_TIMEOUT_DEFAULT = 16;

    localparam logic [IC0_DATA_W-1:0] IC0_RD_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RD_WAIT,
        RSP
    } ic0_state_e;

    // Saturating increment so the wait counter never wraps back to zero.
    function automatic logic [IC0_CNT_W-1:0] sat_inc(input logic [IC0_CNT_W-1:0] v);
        return (v == '1) ? v : v + IC0_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ic0_bus_master_if.sv
// Host request/response handshake plus the ic0 strobe/return bus seen by the bus master.
interface ic0_bus_master_if
    import ic0_bus_pkg::*;
#(
    parameter int N_SLV = IC0_N_SLV_DEFAULT
) ();

    logic                        host_req_valid;
    logic                        host_req_ready;
    logic                        host_req_we;
    logic [IC0_DATA_W-1:0]       host_req_addr;
    logic [IC0_DATA_W-1:0]       host_req_wdata;
    logic                        host_rsp_valid;
    logic                        host_rsp_ready;
    logic [IC0_DATA_W-1:0]       host_rsp_rdata;
    logic                        host_rsp_err;

    logic                        ic0_c_axi_mst_wr_valid;
    logic                        ic0_c_axi_mst_rd_valid;
    logic [IC0_DATA_W-1:0]       ic0_axi_mst_wr_addr;
    logic [IC0_DATA_W-1:0]       ic0_axi_mst_rd_addr;
    logic [IC0_DATA_W-1:0]       ic0_axi_mst_wr_data;
    logic [N_SLV-1:0]            ic0_c_axi_slv_rd_ready;
    logic [N_SLV*IC0_DATA_W-1:0] ic0_axi_slv_rd_data;

    modport master (
        input  host_req_valid,
        output host_req_ready,
        input  host_req_we,
        input  host_req_addr,
        input  host_req_wdata,
        output host_rsp_valid,
        input  host_rsp_ready,
        output host_rsp_rdata,
        output host_rsp_err,
        output ic0_c_axi_mst_wr_valid,
        output ic0_c_axi_mst_rd_valid,
        output ic0_axi_mst_wr_addr,
        output ic0_axi_mst_rd_addr,
        output ic0_axi_mst_wr_data,
        input  ic0_c_axi_slv_rd_ready,
        input  ic0_axi_slv_rd_data
    );

    modport slave (
        output host_req_valid,
        input  host_req_ready,
        output host_req_we,
        output host_req_addr,
        output host_req_wdata,
        input  host_rsp_valid,
        output host_rsp_ready,
        input  host_rsp_rdata,
        input  host_rsp_err,
        input  ic0_c_axi_mst_wr_valid,
        input  ic0_c_axi_mst_rd_valid,
        input  ic0_axi_mst_wr_addr,
        input  ic0_axi_mst_rd_addr,
        input  ic0_axi_mst_wr_data,
        output ic0_c_axi_slv_rd_ready,
        output ic0_axi_slv_rd_data
    );

endinterface

// File: rtl/ic0_rd_collect.sv
// Combinational merge of the per-slave read returns: OR of all data slices plus hit flags.
module ic0_rd_collect
    import ic0_bus_pkg::*;
#(
    parameter int N_SLV = IC0_N_SLV_DEFAULT
) (
    input  logic [N_SLV-1:0]            rd_ready,
    input  logic [N_SLV*IC0_DATA_W-1:0] rd_data,
    output logic [IC0_DATA_W-1:0]       or_data,
    output logic                        hit_one,
    output logic                        hit_multi,
    output logic                        hit_none
);

    // Idle slaves drive zero, so a plain OR recovers the returning slave's data.
    always_comb begin
        or_data = '0;
        for (int i = 0; i < N_SLV; i++) begin
            or_data = or_data | rd_data[i*IC0_DATA_W +: IC0_DATA_W];
        end
    end

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign hit_multi = |(rd_ready & (rd_ready - N_SLV'(1)));
    assign hit_none  = ~(|rd_ready);
    assign hit_one   = ~hit_none & ~hit_multi;

endmodule

// File: rtl/ic0_bus_master.sv
// Single-outstanding ic0 bus master: turns host handshakes into one-cycle ic0 strobes
// and returns the collected read data, with a timeout for unclaimed reads.
module ic0_bus_master
    import ic0_bus_pkg::*;
#(
    parameter int N_SLV   = IC0_N_SLV_DEFAULT,
    parameter int TIMEOUT = IC0_TIMEOUT_DEFAULT
) (
    input logic              clk,
    input logic              reset,
    ic0_bus_master_if.master bus
);

    localparam logic [IC0_CNT_W-1:0] TIMEOUT_CNT = IC0_CNT_W'(TIMEOUT);

    ic0_state_e            state;
    ic0_state_e            state_next;
    logic                  we_q;
    logic [IC0_DATA_W-1:0] addr_q;
    logic [IC0_DATA_W-1:0] wdata_q;
    logic [IC0_DATA_W-1:0] rdata_q;
    logic                  err_q;
    logic [IC0_CNT_W-1:0]  cnt_q;
    logic [IC0_CNT_W-1:0]  cnt_inc;

    logic [IC0_DATA_W-1:0] or_data;
    logic                  hit_one;
    logic                  hit_multi;
    logic                  hit_none;
    logic                  hit_any;
    logic                  timeout_hit;

    ic0_rd_collect #(
        .N_SLV (N_SLV)
    ) u_collect (
        .rd_ready  (bus.ic0_c_axi_slv_rd_ready),
        .rd_data   (bus.ic0_axi_slv_rd_data),
        .or_data   (or_data),
        .hit_one   (hit_one),
        .hit_multi (hit_multi),
        .hit_none  (hit_none)
    );

    assign hit_any     = hit_one | hit_multi;
    assign cnt_inc     = sat_inc(cnt_q);
    // A return in the last allowed wait cycle still wins over the timeout.
    assign timeout_hit = hit_none && (cnt_inc >= TIMEOUT_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.host_req_valid) state_next = ISSUE;
            ISSUE:   state_next = we_q ? RSP : RD_WAIT;
            RD_WAIT: if (hit_any || timeout_hit) state_next = RSP;
            RSP:     if (bus.host_rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.host_req_ready         = (state == IDLE);
        bus.host_rsp_valid         = (state == RSP);
        bus.ic0_c_axi_mst_wr_valid = (state == ISSUE) &&  we_q;
        bus.ic0_c_axi_mst_rd_valid = (state == ISSUE) && !we_q;
    end

    // Request capture, wait counter and response registers; rd_ready only matters in RD_WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.host_req_valid) begin
                        we_q    <= bus.host_req_we;
                        addr_q  <= bus.host_req_addr;
                        wdata_q <= bus.host_req_wdata;
                    end
                end
                ISSUE: begin
                    cnt_q <= '0;
                    if (we_q) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (hit_any) begin
                        rdata_q <= or_data;
                        err_q   <= hit_multi;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (timeout_hit) begin
                            rdata_q <= IC0_RD_ERR_DATA;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.host_rsp_rdata      = rdata_q;
    assign bus.host_rsp_err        = err_q;
    assign bus.ic0_axi_mst_wr_addr = addr_q;
    assign bus.ic0_axi_mst_rd_addr = addr_q;
    assign bus.ic0_axi_mst_wr_data = wdata_q;

endmodule

// File: tb/tb_ic0_bus_master.sv
// Directed bench for ic0_bus_master: a small GPIO slave model on slot 0 plus stub returns
// driven per vector, then hand sequences for backpressure, late returns and reset mid-read.
module tb_ic0_bus_master;

    localparam int NS    = 4;
    localparam int LIMIT = 40;
    localparam logic [31:0] GPIO_PINS = 32'h0000000A;

    typedef struct {
        logic           we;
        logic [31:0]    addr;
        logic [31:0]    wdata;
        int             k;
        logic [NS-1:0]  mask;
        logic [NS*32-1:0] data;
        logic [31:0]    exp_rdata;
        logic           exp_err;
        int             exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;

    logic [NS-1:0]    stub_ready = '0;
    logic [NS*32-1:0] stub_data  = '0;
    logic [31:0]      gpio_dir   = '0;
    logic [31:0]      gpio_out   = '0;
    logic [31:0]      gpio_rdata = '0;
    logic             gpio_ret   = 1'b0;

    vec_t vecs[10];

    ic0_bus_master_if #(.N_SLV(NS)) bus ();

    ic0_bus_master #(
        .N_SLV   (NS),
        .TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // GPIO at 0x440..0x47F: dir at +4, out at +8, pins at +0x20; one-cycle registered return.
    always @(posedge clk) begin
        if (bus.ic0_c_axi_mst_wr_valid && bus.ic0_axi_mst_wr_addr == 32'h444) gpio_dir <= bus.ic0_axi_mst_wr_data;
        if (bus.ic0_c_axi_mst_wr_valid && bus.ic0_axi_mst_wr_addr == 32'h448) gpio_out <= bus.ic0_axi_mst_wr_data;
        gpio_ret <= bus.ic0_c_axi_mst_rd_valid && (bus.ic0_axi_mst_rd_addr[31:6] == 26'h11);
        case (bus.ic0_axi_mst_rd_addr)
            32'h444: gpio_rdata <= gpio_dir;
            32'h448: gpio_rdata <= gpio_out;
            32'h460: gpio_rdata <= GPIO_PINS;
            default: gpio_rdata <= 32'h0;
        endcase
    end

    assign bus.ic0_c_axi_slv_rd_ready = stub_ready | {{(NS-1){1'b0}}, gpio_ret};
    assign bus.ic0_axi_slv_rd_data    = stub_data | {{(NS*32-32){1'b0}}, (gpio_ret ? gpio_rdata : 32'h0)};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present a request in IDLE, let it be accepted, and check the strobe cycle.
    task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input string name);
        bus.host_req_valid = 1'b1;
        bus.host_req_we    = we;
        bus.host_req_addr  = addr;
        bus.host_req_wdata = wdata;
        check_output({name, ".req_ready"}, 32'(bus.host_req_ready), 32'd1);
        tick();
        bus.host_req_valid = 1'b0;
        check_output({name, ".wr_valid"}, 32'(bus.ic0_c_axi_mst_wr_valid), 32'(we));
        check_output({name, ".rd_valid"}, 32'(bus.ic0_c_axi_mst_rd_valid), 32'(!we));
        check_output({name, ".wr_addr"}, bus.ic0_axi_mst_wr_addr, addr);
        check_output({name, ".rd_addr"}, bus.ic0_axi_mst_rd_addr, addr);
        if (we) check_output({name, ".wr_data"}, bus.ic0_axi_mst_wr_data, wdata);
        check_output({name, ".busy"}, 32'(bus.host_req_ready), 32'd0);
    endtask

    // Count cycles from acceptance until rsp_valid; optionally inject a stub return in cycle T+1+k.
    task automatic wait_rsp(input int k, input logic [NS-1:0] mask, input logic [NS*32-1:0] data,
                            output int lat, output int extra);
        lat   = 1;
        extra = 0;
        while (1) begin
            tick();
            lat++;
            stub_ready = '0;
            stub_data  = '0;
            if (bus.ic0_c_axi_mst_wr_valid || bus.ic0_c_axi_mst_rd_valid) extra++;
            if (bus.host_rsp_valid || lat >= LIMIT) break;
            if (k > 0 && lat == 1 + k) begin
                stub_ready = mask;
                stub_data  = data;
            end
        end
    endtask

    task automatic accept_rsp(input string name);
        bus.host_rsp_ready = 1'b1;
        tick();
        bus.host_rsp_ready = 1'b0;
        check_output({name, ".rsp_drop"}, 32'(bus.host_rsp_valid), 32'd0);
        check_output({name, ".idle"}, 32'(bus.host_req_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        int extra;
        apply_stimulus(v.we, v.addr, v.wdata, name);
        wait_rsp(v.k, v.mask, v.data, lat, extra);
        check_output({name, ".latency"}, 32'(lat), 32'(v.exp_lat));
        check_output({name, ".strobe_once"}, 32'(extra), 32'd0);
        check_output({name, ".rdata"}, bus.host_rsp_rdata, v.exp_rdata);
        check_output({name, ".err"}, 32'(bus.host_rsp_err), 32'(v.exp_err));
        accept_rsp(name);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int extra;

        vecs[0] = '{1'b1, 32'h444, 32'h0000000F, 0, 4'b0000, 128'h0, 32'h0, 1'b0, 2};
        vecs[1] = '{1'b0, 32'h444, 32'h0, 0, 4'b0000, 128'h0, 32'h0000000F, 1'b0, 3};
        vecs[2] = '{1'b0, 32'h460, 32'h0, 0, 4'b0000, 128'h0, 32'h0000000A, 1'b0, 3};
        vecs[3] = '{1'b1, 32'h448, 32'h12345678, 0, 4'b0000, 128'h0, 32'h0, 1'b0, 2};
        vecs[4] = '{1'b0, 32'h448, 32'h0, 0, 4'b0000, 128'h0, 32'h12345678, 1'b0, 3};
        vecs[5] = '{1'b0, 32'h900, 32'h0, 0, 4'b0000, 128'h0, 32'hDEADBEEF, 1'b1, 18};
        vecs[6] = '{1'b0, 32'h800, 32'h0, 1, 4'b0101, {32'h0, 32'h4, 32'h0, 32'h1}, 32'h5, 1'b1, 3};
        vecs[7] = '{1'b0, 32'h810, 32'h0, 4, 4'b1000, {32'hCAFE, 32'h0, 32'h0, 32'h0}, 32'hCAFE, 1'b0, 6};
        vecs[8] = '{1'b0, 32'h820, 32'h0, 2, 4'b0110, {32'h0, 32'h0F, 32'hF0, 32'h0}, 32'hFF, 1'b1, 4};
        vecs[9] = '{1'b0, 32'h830, 32'h0, 16, 4'b0010, {32'h0, 32'h0, 32'h1234, 32'h0}, 32'h1234, 1'b0, 18};

        reset              = 1'b1;
        bus.host_req_valid = 1'b0;
        bus.host_req_we    = 1'b0;
        bus.host_req_addr  = '0;
        bus.host_req_wdata = '0;
        bus.host_rsp_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        check_output("reset.req_ready", 32'(bus.host_req_ready), 32'd1);
        check_output("reset.rsp_valid", 32'(bus.host_rsp_valid), 32'd0);
        check_output("reset.rsp_rdata", bus.host_rsp_rdata, 32'h0);
        check_output("reset.rsp_err", 32'(bus.host_rsp_err), 32'd0);
        check_output("reset.strobes", 32'({bus.ic0_c_axi_mst_wr_valid, bus.ic0_c_axi_mst_rd_valid}), 32'd0);
        check_output("reset.wr_addr", bus.ic0_axi_mst_wr_addr, 32'h0);
        check_output("reset.rd_addr", bus.ic0_axi_mst_rd_addr, 32'h0);
        check_output("reset.wr_data", bus.ic0_axi_mst_wr_data, 32'h0);
        tick();

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: response held for 5 cycles while the next request waits.
        apply_stimulus(1'b0, 32'h460, 32'h0, "bp");
        wait_rsp(0, '0, '0, lat, extra);
        check_output("bp.latency", 32'(lat), 32'd3);
        bus.host_req_valid = 1'b1;
        bus.host_req_we    = 1'b0;
        bus.host_req_addr  = 32'h444;
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("bp.hold%0d.valid", i), 32'(bus.host_rsp_valid), 32'd1);
            check_output($sformatf("bp.hold%0d.rdata", i), bus.host_rsp_rdata, 32'h0000000A);
            check_output($sformatf("bp.hold%0d.err", i), 32'(bus.host_rsp_err), 32'd0);
            check_output($sformatf("bp.hold%0d.req_ready", i), 32'(bus.host_req_ready), 32'd0);
            tick();
        end
        bus.host_rsp_ready = 1'b1;
        tick();
        bus.host_rsp_ready = 1'b0;
        check_output("bp.next_ready", 32'(bus.host_req_ready), 32'd1);
        tick();
        bus.host_req_valid = 1'b0;
        check_output("bp.next_rd_valid", 32'(bus.ic0_c_axi_mst_rd_valid), 32'd1);
        check_output("bp.next_addr", bus.ic0_axi_mst_rd_addr, 32'h444);
        wait_rsp(0, '0, '0, lat, extra);
        check_output("bp.next_latency", 32'(lat), 32'd3);
        check_output("bp.next_rdata", bus.host_rsp_rdata, 32'h0000000F);
        accept_rsp("bp.next");

        // Late return after a timeout must neither alter the response nor create a second one.
        apply_stimulus(1'b0, 32'h900, 32'h0, "late");
        wait_rsp(0, '0, '0, lat, extra);
        check_output("late.latency", 32'(lat), 32'd18);
        tick();
        tick();
        stub_ready = 4'b0010;
        stub_data  = {32'h0, 32'h0, 32'h55, 32'h0};
        tick();
        stub_ready = '0;
        stub_data  = '0;
        check_output("late.rsp_valid", 32'(bus.host_rsp_valid), 32'd1);
        check_output("late.rdata", bus.host_rsp_rdata, 32'hDEADBEEF);
        check_output("late.err", 32'(bus.host_rsp_err), 32'd1);
        accept_rsp("late");
        stub_ready = 4'b0010;
        stub_data  = {32'h0, 32'h0, 32'h55, 32'h0};
        tick();
        stub_ready = '0;
        stub_data  = '0;
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("late.idle%0d.rsp_valid", i), 32'(bus.host_rsp_valid), 32'd0);
            tick();
        end

        // Reset while waiting in RD_WAIT: straight back to IDLE, pending read forgotten.
        apply_stimulus(1'b0, 32'h900, 32'h0, "rst");
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_output("rst.req_ready", 32'(bus.host_req_ready), 32'd1);
        check_output("rst.rsp_valid", 32'(bus.host_rsp_valid), 32'd0);
        check_output("rst.strobes", 32'({bus.ic0_c_axi_mst_wr_valid, bus.ic0_c_axi_mst_rd_valid}), 32'd0);
        check_output("rst.rd_addr", bus.ic0_axi_mst_rd_addr, 32'h0);
        stub_ready = 4'b0100;
        stub_data  = {32'h0, 32'h77, 32'h0, 32'h0};
        tick();
        stub_ready = '0;
        stub_data  = '0;
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("rst.idle%0d.rsp_valid", i), 32'(bus.host_rsp_valid), 32'd0);
            tick();
        end
        run_vec(vecs[2], "rst.after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
